pipeline_4array_ctrl: RTL and testbench

PIPELINE_4ARRAY_CTRL -- requirements
Module: pipeline_4array_ctrl

---
 rtl/pipeline_pkg.sv | 19 +
 rtl/pipeline_4array_ctrl_if.sv | 34 +++
 rtl/tile_addr_gen.sv | 41 ++++
 rtl/pipeline_4array_ctrl.sv | 114 +++++++++++
 tb/tb_pipeline_4array_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the tile-array pipeline controller: datapath mode encoding and
// controller FSM states.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ModeMac     = 2'b00,
    ModeEwm     = 2'b01,
    ModeEwa     = 2'b10,
    ModeIllegal = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/pipeline_4array_ctrl_if.sv
// Command, operand, datapath and sink signals of the tile-array controller.
// The controller is the slave of this bundle; its environment is the master.
interface pipeline_4array_ctrl_if #(
  parameter int unsigned IDX_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic [IDX_W-1:0] cmd_rows;
  logic [IDX_W-1:0] cmd_cols;
  logic             cmd_err;
  logic             opnd_valid;
  logic             opnd_pop;
  logic [IDX_W-1:0] tile_row;
  logic [IDX_W-1:0] tile_col;
  logic [1:0]       pe_mode;
  logic             pe_valid_in;
  logic             pe_valid_out;
  logic             res_pop;
  logic             job_busy;
  logic             job_done;

  modport slave (
    input  cmd_valid, cmd_mode, cmd_rows, cmd_cols, opnd_valid, pe_valid_out, res_pop,
    output cmd_ready, cmd_err, opnd_pop, tile_row, tile_col, pe_mode, pe_valid_in,
           job_busy, job_done
  );

  modport master (
    output cmd_valid, cmd_mode, cmd_rows, cmd_cols, opnd_valid, pe_valid_out, res_pop,
    input  cmd_ready, cmd_err, opnd_pop, tile_row, tile_col, pe_mode, pe_valid_in,
           job_busy, job_done
  );
endinterface

// File: rtl/tile_addr_gen.sv
// Row-major tile index walker: col advances per step and wraps into the next row.
// 'last' flags the final (rows-1, cols-1) position.
module tile_addr_gen #(
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             step,
  input  logic [IDX_W-1:0] rows,
  input  logic [IDX_W-1:0] cols,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic             last
);
  logic [IDX_W-1:0] row_q, col_q;
  logic             col_end;

  assign col_end = (col_q == cols - IDX_W'(1));
  assign last    = col_end && (row_q == rows - IDX_W'(1));
  assign row     = row_q;
  assign col     = col_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else if (clear) begin
      row_q <= '0;
      col_q <= '0;
    end else if (step && !last) begin
      // Holds at the final tile so the indices stay meaningful while draining.
      if (col_end) begin
        col_q <= '0;
        row_q <= row_q + IDX_W'(1);
      end else begin
        col_q <= col_q + IDX_W'(1);
      end
    end
  end
endmodule

// File: rtl/pipeline_4array_ctrl.sv
// Job controller for a tiled processing array: walks tile indices, gates issue on
// in-flight and sink-credit limits, and signals completion by issue/return counting.
module pipeline_4array_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned TILE_SIZE    = 4,
  parameter int unsigned MAX_INFLIGHT = 16,
  parameter int unsigned CREDITS      = 8,
  parameter int unsigned IDX_W        = 8
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_4array_ctrl_if.slave bus
);
  localparam int unsigned InflightW = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned CreditW   = $clog2(CREDITS + 1);

  if (TILE_SIZE == 0 || IDX_W == 0) begin : g_param_check
    $error("pipeline_4array_ctrl: TILE_SIZE and IDX_W must be non-zero");
  end

  state_e               state_q, state_d;
  mode_e                mode_q;
  logic [IDX_W-1:0]     rows_q, cols_q;
  logic [InflightW-1:0] inflight_q, inflight_d;
  logic [CreditW-1:0]   credits_q, credits_d;
  logic                 cmd_err_q;
  logic                 accept, legal, issue, ret, pop, gen_clear, last;

  assign accept = (state_q == StIdle) && bus.cmd_valid;
  assign legal  = accept && (bus.cmd_mode != ModeIllegal);
  // Strobes that would under/overflow a counter are dropped.
  assign ret    = bus.pe_valid_out && (inflight_q != '0);
  assign pop    = bus.res_pop && (credits_q != CreditW'(CREDITS));

  always_comb begin
    state_d   = state_q;
    gen_clear = 1'b0;
    issue     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (legal) begin
          gen_clear = 1'b1;
          state_d   = (bus.cmd_rows == '0 || bus.cmd_cols == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        issue = bus.opnd_valid && (inflight_q < InflightW'(MAX_INFLIGHT)) &&
                (credits_q != '0);
        if (issue && last) state_d = StDrain;
      end
      StDrain: begin
        if (inflight_q == '0 || (inflight_q == InflightW'(1) && bus.pe_valid_out)) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    credits_d  = credits_q;
    if (issue && !ret) inflight_d = inflight_q + InflightW'(1);
    if (ret && !issue) inflight_d = inflight_q - InflightW'(1);
    if (pop && !issue) credits_d = credits_q + CreditW'(1);
    if (issue && !pop) credits_d = credits_q - CreditW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      mode_q     <= ModeMac;
      rows_q     <= '0;
      cols_q     <= '0;
      inflight_q <= '0;
      credits_q  <= CreditW'(CREDITS);
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      credits_q  <= credits_d;
      cmd_err_q  <= accept && (bus.cmd_mode == ModeIllegal);
      if (legal) begin
        mode_q <= mode_e'(bus.cmd_mode);
        rows_q <= bus.cmd_rows;
        cols_q <= bus.cmd_cols;
      end
    end
  end

  tile_addr_gen #(
    .IDX_W (IDX_W)
  ) u_addr_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (gen_clear),
    .step  (issue),
    .rows  (rows_q),
    .cols  (cols_q),
    .row   (bus.tile_row),
    .col   (bus.tile_col),
    .last  (last)
  );

  assign bus.cmd_ready   = (state_q == StIdle);
  assign bus.cmd_err     = cmd_err_q;
  assign bus.pe_valid_in = issue;
  assign bus.opnd_pop    = issue;
  assign bus.pe_mode     = mode_q;
  assign bus.job_busy    = (state_q == StIssue) || (state_q == StDrain);
  assign bus.job_done    = (state_q == StDone);
endmodule

// File: tb/tb_pipeline_4array_ctrl.sv
// Directed bench for pipeline_4array_ctrl with a fixed-latency datapath model and a
// sink model; expectations are hand-computed per scenario.
module tb_pipeline_4array_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;

  pipeline_4array_ctrl_if #(.IDX_W(8)) bus ();

  pipeline_4array_ctrl #(
    .TILE_SIZE    (4),
    .MAX_INFLIGHT (16),
    .CREDITS      (8),
    .IDX_W        (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Datapath model: results return 4 cycles after issue when enabled.
  logic       ret_en = 1'b0, pop_en = 1'b0, force_ret = 1'b0, man_pop = 1'b0;
  logic       iss = 1'b0;
  logic [3:0] pipe = '0;
  assign bus.pe_valid_out = (ret_en && pipe[3]) || force_ret;
  assign bus.res_pop      = (pop_en && pipe[3]) || man_pop;

  initial forever begin
    @(posedge clk);
    #1;
    pipe = {pipe[2:0], iss};
  end

  // Monitor at negedge: a high pe_valid_in here is an issue at the next rising edge.
  int         cyc = 0;
  int         n_iss = 0, n_done = 0, n_err = 0;
  int         last_iss_cyc = 0, done_cyc = 0;
  logic [7:0] log_row [64];
  logic [7:0] log_col [64];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    iss = bus.pe_valid_in && !rst;
    if (!rst) begin
      if (bus.pe_valid_in) begin
        if (n_iss < 64) begin
          log_row[n_iss] = bus.tile_row;
          log_col[n_iss] = bus.tile_col;
        end
        last_iss_cyc = cyc + 1;
        n_iss++;
      end
      if (bus.job_done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (bus.cmd_err) n_err++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_cmd(input logic [1:0] mode, input logic [7:0] rows,
                          input logic [7:0] cols);
    bus.cmd_mode  = mode;
    bus.cmd_rows  = rows;
    bus.cmd_cols  = cols;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start = n_done;
    int k = 0;
    while (n_done == start && k < budget) begin
      tick();
      k++;
    end
    check(tag, n_done - start, 1);
  endtask

  int base, d0;

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_mode   = 2'b00;
    bus.cmd_rows   = '0;
    bus.cmd_cols   = '0;
    bus.opnd_valid = 1'b0;

    // Reset values
    #2;
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_pe_valid_in", bus.pe_valid_in, 0);
    check("rst_job_busy", bus.job_busy, 0);
    check("rst_job_done", bus.job_done, 0);
    check("rst_cmd_err", bus.cmd_err, 0);
    check("rst_tile_idx", {bus.tile_row, bus.tile_col}, 0);
    check("rst_pe_mode", bus.pe_mode, 0);
    #20;
    rst = 1'b0;
    tick();

    // MAC 2x3 with 4-cycle returns and prompt sink pops
    ret_en = 1'b1;
    pop_en = 1'b1;
    bus.opnd_valid = 1'b1;
    base = n_iss;
    d0 = n_done;
    send_cmd(2'b00, 8'd2, 8'd3);
    check("mac_busy", bus.job_busy, 1);
    check("mac_ready_low", bus.cmd_ready, 0);
    wait_done("mac_done", 60);
    check("mac_issues", n_iss - base, 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("mac_idx%0d", i), {log_row[base + i], log_col[base + i]},
            {8'(i / 3), 8'(i % 3)});
    end
    check("mac_done_lat", done_cyc - last_iss_cyc, 4);
    tick();
    tick();
    tick();
    check("mac_done_once", n_done - d0, 1);
    check("mac_idle_ready", bus.cmd_ready, 1);

    // Illegal mode
    base = n_iss;
    send_cmd(2'b11, 8'd2, 8'd2);
    check("ill_err_pulse", bus.cmd_err, 1);
    check("ill_no_issue", bus.pe_valid_in, 0);
    check("ill_stay_idle", bus.cmd_ready, 1);
    tick();
    check("ill_err_clear", bus.cmd_err, 0);
    tick();
    check("ill_err_count", n_err, 1);
    check("ill_issue_count", n_iss - base, 0);

    // Credit stall: 1x16, no sink pops
    ret_en = 1'b0;
    pop_en = 1'b0;
    base = n_iss;
    send_cmd(2'b01, 8'd1, 8'd16);
    repeat (20) tick();
    check("cred_stall_issues", n_iss - base, 8);
    check("cred_stall_pvi", bus.pe_valid_in, 0);
    check("cred_pe_mode", bus.pe_mode, 2'b01);
    man_pop = 1'b1;
    tick();
    man_pop = 1'b0;
    tick();
    man_pop = 1'b1;
    tick();
    man_pop = 1'b0;
    repeat (4) tick();
    check("cred_two_more", n_iss - base, 10);
    force_ret = 1'b1;
    man_pop = 1'b1;
    wait_done("cred_done", 100);
    check("cred_total", n_iss - base, 16);
    force_ret = 1'b0;
    repeat (10) tick();

    // In-flight cap: 1x20, returns stalled, sink always freeing
    base = n_iss;
    send_cmd(2'b10, 8'd1, 8'd20);
    repeat (25) tick();
    check("cap_issues", n_iss - base, 16);
    check("cap_stall_pvi", bus.pe_valid_in, 0);
    force_ret = 1'b1;
    tick();
    check("cap_after_ret_pvi", bus.pe_valid_in, 1);
    tick();
    force_ret = 1'b0;
    check("cap_both_pvi", bus.pe_valid_in, 1);
    tick();
    check("cap_refull_pvi", bus.pe_valid_in, 0);
    check("cap_issues2", n_iss - base, 18);
    force_ret = 1'b1;
    wait_done("cap_done", 100);
    check("cap_total", n_iss - base, 20);
    force_ret = 1'b0;
    man_pop = 1'b0;
    repeat (5) tick();

    // Empty job
    base = n_iss;
    send_cmd(2'b10, 8'd0, 8'd5);
    check("empty_done", bus.job_done, 1);
    check("empty_busy", bus.job_busy, 0);
    check("empty_ready", bus.cmd_ready, 0);
    check("empty_pvi", bus.pe_valid_in, 0);
    tick();
    check("empty_done_clear", bus.job_done, 0);
    check("empty_ready_back", bus.cmd_ready, 1);
    check("empty_issues", n_iss - base, 0);

    // Reset mid-ISSUE after 3 issues
    base = n_iss;
    send_cmd(2'b01, 8'd2, 8'd3);
    tick();
    tick();
    tick();
    check("mid_issues", n_iss - base, 3);
    check("mid_idx", {bus.tile_row, bus.tile_col}, {8'd1, 8'd0});
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_pvi", bus.pe_valid_in, 0);
    check("mid_rst_pop", bus.opnd_pop, 0);
    check("mid_rst_busy", bus.job_busy, 0);
    check("mid_rst_idx", {bus.tile_row, bus.tile_col}, 0);
    check("mid_rst_mode", bus.pe_mode, 0);
    check("mid_rst_ready", bus.cmd_ready, 1);
    #13;
    rst = 1'b0;
    tick();
    ret_en = 1'b1;
    pop_en = 1'b1;
    base = n_iss;
    send_cmd(2'b00, 8'd1, 8'd2);
    wait_done("restart_done", 40);
    check("restart_issues", n_iss - base, 2);
    check("restart_idx0", {log_row[base], log_col[base]}, 0);
    check("restart_idx1", {log_row[base + 1], log_col[base + 1]}, {8'd0, 8'd1});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
